gray_decode: RTL and testbench

GRAY_DECODE -- requirements
Module: gray_decode

---
 rtl/gray_decode.sv | 96 +++++++++
 tb/tb_gray_decode.sv | 121 ++++++++++++
 2 files changed

// File: rtl/gray_decode.sv
// Registered Gray-to-binary decoder that tracks count continuity and flags wrap and illegal steps.
// Optional macro GRAY_DECODE_CHECK_EN compiles in step checking (Error flag and FAULT state).
module gray_decode #(
  parameter int WIDTH = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Valid,
  input  logic [WIDTH-1:0] In,
  input  logic             Clear,
  output logic [WIDTH-1:0] Out,
  output logic             OutValid,
  output logic             Overflow,
  output logic             Error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] bin;
  logic             wrap;

  always_comb begin
    bin = '0;
    bin[WIDTH-1] = In[WIDTH-1];
    for (int unsigned k = 1; k < WIDTH; k++) begin
      bin[WIDTH-1-k] = bin[WIDTH-k] ^ In[WIDTH-1-k];
    end
  end

  assign wrap = (Out == '1) && (bin == '0);

`ifdef GRAY_DECODE_CHECK_EN
  logic [WIDTH-1:0] next;
  logic             err;

  assign next  = Out + 1'b1;
  assign Error = err;
`else
  assign Error = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Out      <= '0;
      OutValid <= 1'b0;
      Overflow <= 1'b0;
      state    <= IDLE;
`ifdef GRAY_DECODE_CHECK_EN
      err      <= 1'b0;
`endif
    end else begin
      OutValid <= 1'b0;
      if (Clear) begin
        // Out is deliberately kept; a Valid in the same cycle is dropped.
        Overflow <= 1'b0;
        state    <= IDLE;
`ifdef GRAY_DECODE_CHECK_EN
        err      <= 1'b0;
`endif
      end else if (Valid) begin
        case (state)
          IDLE: begin
            Out      <= bin;
            OutValid <= 1'b1;
            state    <= TRACK;
          end
          TRACK: begin
`ifdef GRAY_DECODE_CHECK_EN
            if (bin == Out) begin
              OutValid <= 1'b1;
            end else if (bin == next) begin
              Out      <= bin;
              OutValid <= 1'b1;
              if (wrap) Overflow <= 1'b1;
            end else begin
              err   <= 1'b1;
              state <= FAULT;
            end
`else
            Out      <= bin;
            OutValid <= 1'b1;
            if (wrap) Overflow <= 1'b1;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gray_decode.sv
// Directed table-driven bench for gray_decode at WIDTH=3, with hand sequences for the step-error path.
module tb_gray_decode;

  localparam int W = 3;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         Valid = 1'b0;
  logic [W-1:0] In = '0;
  logic         Clear = 1'b0;
  logic [W-1:0] Out;
  logic         OutValid;
  logic         Overflow;
  logic         Error;

  int tests = 0;
  int fails = 0;

  gray_decode #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Valid(Valid), .In(In), .Clear(Clear),
    .Out(Out), .OutValid(OutValid), .Overflow(Overflow), .Error(Error)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic         rst;
    logic         clr;
    logic         vld;
    logic [W-1:0] gin;
    logic [W-1:0] eout;
    logic         eov;
    logic         eovf;
    logic         eerr;
  } vec_t;

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input logic rst, input logic clr, input logic vld, input logic [W-1:0] gin);
    Reset = rst; Clear = clr; Valid = vld; In = gin;
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_all(input int idx, input logic [W-1:0] eo, input logic eov,
                            input logic eovf, input logic eerr);
    chk("out", idx, 16'(Out), 16'(eo));
    chk("outvalid", idx, 16'(OutValid), 16'(eov));
    chk("overflow", idx, 16'(Overflow), 16'(eovf));
    chk("error", idx, 16'(Error), 16'(eerr));
  endtask

  vec_t vecs[20];

  initial begin
    //         rst   clr   vld   gray    out   ov    ovf   err
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 3'b111, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 3'b000, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 3'b001, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 3'b011, 3'd2, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 3'b010, 3'd3, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 3'b110, 3'd4, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 3'b111, 3'd5, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 3'b101, 3'd6, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 3'b100, 3'd7, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 3'b000, 3'd0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 3'b001, 3'd1, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 3'b011, 3'd1, 1'b0, 1'b1, 1'b0};
    // Clear wins over Valid: sample dropped, Out kept, next sample is unchecked
    vecs[12] = '{1'b0, 1'b1, 1'b1, 3'b011, 3'd1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 3'b011, 3'd2, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 3'b011, 3'd2, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 3'b011, 3'd2, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 3'b010, 3'd3, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 3'b111, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 3'b101, 3'd6, 1'b1, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 3'b100, 3'd7, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 20; i++) begin
      apply(vecs[i].rst, vecs[i].clr, vecs[i].vld, vecs[i].gin);
      expect_all(i, vecs[i].eout, vecs[i].eov, vecs[i].eovf, vecs[i].eerr);
    end

    // Non-unit step 1 -> 3
    apply(1'b1, 1'b0, 1'b0, 3'b000);
    expect_all(100, 3'd0, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 3'b001);
    expect_all(101, 3'd1, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 3'b010);
`ifdef GRAY_DECODE_CHECK_EN
    expect_all(102, 3'd1, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 1'b0, 1'b1, 3'b110);
    expect_all(103, 3'd1, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 1'b0, 1'b1, 3'b011);
    expect_all(104, 3'd1, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 1'b1, 1'b0, 3'b000);
    expect_all(105, 3'd1, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 3'b110);
    expect_all(106, 3'd4, 1'b1, 1'b0, 1'b0);
`else
    expect_all(102, 3'd3, 1'b1, 1'b0, 1'b0);
    // Wrap via arbitrary jumps still sets Overflow
    apply(1'b0, 1'b0, 1'b1, 3'b100);
    expect_all(103, 3'd7, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 3'b000);
    expect_all(104, 3'd0, 1'b1, 1'b1, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 3'b000);
    expect_all(105, 3'd0, 1'b0, 1'b1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
